// File: rtl/morty_lsu_bus.sv
// Load/store unit bus master.
// Turns one pipeline memory request into a single Wishbone classic cycle.
// Stores have their data replicated across the selected byte lanes.
// Load words are returned raw, and the downstream load unit extracts the
// wanted bytes from them.
// A request ends in one of three ways: ack, err/timeout, or a pipeline kill
// (the kill applies to loads only).
module morty_lsu_bus #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  input  logic        kill_i,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic [31:0] data_mem_o,
  output logic [1:0]  addr_lsb_o,
  output logic [2:0]  funct3_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic [31:0] data_mem_q, data_mem_d;
  logic [1:0]  addr_lsb_q, addr_lsb_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        misaligned_q, misaligned_d;
  logic        bus_err_q, bus_err_d;

  logic        req_misaligned;
  logic [3:0]  req_sel;
  logic [31:0] req_wdata;

  // Decode the incoming request: alignment check, byte lanes, lane-replicated store data
  always_comb begin
    req_misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                     (funct3_i[1] && (addr_i[1:0] != 2'b00));
    case (funct3_i[1:0])
      2'b00: begin
        req_sel   = 4'b0001 << addr_i[1:0];
        req_wdata = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        req_sel   = addr_i[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{wdata_i[15:0]}};
      end
      default: begin
        req_sel   = 4'b1111;
        req_wdata = wdata_i;
      end
    endcase
  end

  // Next-state and next-output logic; response flags default to a single-cycle pulse
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    we_d         = we_q;
    cyc_d        = cyc_q;
    data_mem_d   = data_mem_q;
    addr_lsb_d   = addr_lsb_q;
    funct3_d     = funct3_q;
    ready_d      = 1'b0;
    misaligned_d = 1'b0;
    bus_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i && !kill_i) begin
          addr_lsb_d = addr_i[1:0];
          funct3_d   = funct3_i;
          if (req_misaligned) begin
            // Trap without touching the bus
            state_d      = RESP;
            ready_d      = 1'b1;
            misaligned_d = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = 8'd0;
            adr_d   = {addr_i[31:2], 2'b00};
            sel_d   = req_sel;
            dat_d   = we_i ? req_wdata : 32'd0;
            we_d    = we_i;
            cyc_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        if (kill_i && !we_q) begin
          // A flushed load is abandoned silently. A store already on the bus must complete.
          state_d = IDLE;
          cyc_d   = 1'b0;
        end else if (wbm_err_i) begin
          state_d   = RESP;
          cyc_d     = 1'b0;
          ready_d   = 1'b1;
          bus_err_d = 1'b1;
        end else if (wbm_ack_i) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          ready_d = 1'b1;
          if (!we_q) begin
            data_mem_d = wbm_dat_i;
          end
        end else if (cnt_q == CNT_LAST) begin
          // A slave that never answers is reported as a bus error
          state_d   = RESP;
          cyc_d     = 1'b0;
          ready_d   = 1'b1;
          bus_err_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
    busy_d = (state_d == ACCESS);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      adr_q        <= 32'd0;
      dat_q        <= 32'd0;
      sel_q        <= 4'd0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
      data_mem_q   <= 32'd0;
      addr_lsb_q   <= 2'd0;
      funct3_q     <= 3'd0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      cyc_q        <= cyc_d;
      data_mem_q   <= data_mem_d;
      addr_lsb_q   <= addr_lsb_d;
      funct3_q     <= funct3_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      misaligned_q <= misaligned_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = dat_q;
  assign wbm_sel_o    = sel_q;
  assign wbm_we_o     = we_q;
  assign wbm_cyc_o    = cyc_q;
  assign wbm_stb_o    = cyc_q;
  assign data_mem_o   = data_mem_q;
  assign addr_lsb_o   = addr_lsb_q;
  assign funct3_o     = funct3_q;
  assign ready_o      = ready_q;
  assign busy_o       = busy_q;
  assign misaligned_o = misaligned_q;
  assign bus_err_o    = bus_err_q;

endmodule
